// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: ALU op codes, flag bit
// positions, sequencer state encoding and the high-beat op mapping.
package alu_pkg;

  localparam logic [7:0] ALU_ADD = 8'h00;
  localparam logic [7:0] ALU_ADC = 8'h01;
  localparam logic [7:0] ALU_SUB = 8'h02;
  localparam logic [7:0] ALU_SBC = 8'h03;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BEAT_LO = 2'd1,
    ST_BEAT_HI = 2'd2,
    ST_DONE    = 2'd3
  } seq_state_e;

  // Only add and subtract have a carry-chained form for the upper byte.
  function automatic logic has_hi_op(input logic [7:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

  // Op used for the upper byte so the carry/borrow of the lower byte is consumed.
  function automatic logic [7:0] hi_op(input logic [7:0] op);
    case (op)
      ALU_ADD: hi_op = ALU_ADC;
      ALU_SUB: hi_op = ALU_SBC;
      default: hi_op = op;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command and result handshake bundle between the CPU decode stage (master)
// and the ALU op sequencer (slave).
interface alu_op_sequencer_if #(
  parameter int DATA_W = 16
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        cmd_op;
  logic [DATA_W-1:0] cmd_x;
  logic [DATA_W-1:0] cmd_y;
  logic              cmd_wide;
  logic              cmd_write;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [3:0]        res_flags;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_wide, cmd_write, res_ready,
    input  cmd_ready, res_valid, res_data, res_flags
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_wide, cmd_write, res_ready,
    output cmd_ready, res_valid, res_data, res_flags
  );

endinterface

// File: rtl/alu_op_sequencer.sv
// ALU op sequencer: takes one command per handshake, drives the synchronous
// ALU wrapper for one beat (narrow) or two carry-chained byte beats (wide
// add/sub), and presents the result and flags on a held result port.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  alu_op_sequencer_if.slave cmd_if,
  output logic [7:0]        alu_op,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic              alu_enable,
  output logic              alu_writeA,
  input  logic [DATA_W-1:0] alu_o,
  input  logic [7:0]        alu_f,
  output logic              busy
);

  seq_state_e        state_q, state_d;
  logic [7:0]        op_q, op_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic              wide_q, wide_d;
  logic              write_q, write_d;
  logic              lo_zero_q, lo_zero_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [3:0]        flags;

  // Upper flag bits of the wrapper are not part of the result.
  logic unused_flags;
  assign unused_flags = &{1'b0, alu_f[7:4]};

  // State and latched command registers; reset aborts any command in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      wide_q     <= 1'b0;
      write_q    <= 1'b0;
      lo_zero_q  <= 1'b0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      x_q        <= x_d;
      y_q        <= y_d;
      wide_q     <= wide_d;
      write_q    <= write_d;
      lo_zero_q  <= lo_zero_d;
      res_data_q <= res_data_d;
    end
  end

  // Next state, command latch and result capture from the wrapper's O output.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    x_d        = x_q;
    y_d        = y_q;
    wide_d     = wide_q;
    write_d    = write_q;
    lo_zero_d  = lo_zero_q;
    res_data_d = res_data_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_if.cmd_valid) begin
          op_d    = cmd_if.cmd_op;
          x_d     = cmd_if.cmd_x;
          y_d     = cmd_if.cmd_y;
          // Wide requests for ops without a carry-chained form run as narrow.
          wide_d  = cmd_if.cmd_wide & has_hi_op(cmd_if.cmd_op);
          write_d = cmd_if.cmd_write;
          state_d = ST_BEAT_LO;
        end
      end
      ST_BEAT_LO: begin
        if (wide_q) begin
          res_data_d = DATA_W'(alu_o[BYTE_W-1:0]);
          lo_zero_d  = (alu_o[BYTE_W-1:0] == '0);
          state_d    = ST_BEAT_HI;
        end else begin
          res_data_d = alu_o;
          state_d    = ST_DONE;
        end
      end
      ST_BEAT_HI: begin
        res_data_d = {alu_o[BYTE_W-1:0], res_data_q[BYTE_W-1:0]};
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        if (cmd_if.res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Wrapper control: enable only during beats, accumulator write only on a narrow beat.
  always_comb begin
    alu_op     = '0;
    alu_x      = '0;
    alu_y      = '0;
    alu_enable = 1'b0;
    alu_writeA = 1'b0;
    case (state_q)
      ST_BEAT_LO: begin
        alu_enable = 1'b1;
        alu_op     = op_q;
        if (wide_q) begin
          alu_x = DATA_W'(x_q[BYTE_W-1:0]);
          alu_y = DATA_W'(y_q[BYTE_W-1:0]);
        end else begin
          alu_x      = x_q;
          alu_y      = y_q;
          alu_writeA = write_q;
        end
      end
      ST_BEAT_HI: begin
        alu_enable = 1'b1;
        alu_op     = hi_op(op_q);
        alu_x      = DATA_W'(x_q[DATA_W-1:BYTE_W]);
        alu_y      = DATA_W'(y_q[DATA_W-1:BYTE_W]);
      end
      default: ;
    endcase
  end

  // Result flags come straight from the wrapper's flag register, which is
  // frozen in DONE; a wide zero flag must cover both bytes.
  always_comb begin
    flags = 4'h0;
    if (state_q == ST_DONE) begin
      flags = alu_f[3:0];
      if (wide_q) flags[FLAG_Z] = lo_zero_q & (res_data_q[DATA_W-1:BYTE_W] == '0);
    end
  end

  assign cmd_if.cmd_ready = (state_q == ST_IDLE);
  assign cmd_if.res_valid = (state_q == ST_DONE);
  assign cmd_if.res_data  = res_data_q;
  assign cmd_if.res_flags = flags;
  assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: drives directed then random commands through a
// behavioural ALU wrapper and checks results against a command-level model.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int NCMD = 40;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.DATA_W(16)) bus ();

  logic [7:0]  alu_op;
  logic [15:0] alu_x, alu_y, alu_o;
  logic        alu_enable, alu_writeA, busy;
  logic [7:0]  alu_f;

  alu_op_sequencer #(.DATA_W(16), .BYTE_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_if     (bus.slave),
    .alu_op     (alu_op),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_enable (alu_enable),
    .alu_writeA (alu_writeA),
    .alu_o      (alu_o),
    .alu_f      (alu_f),
    .busy       (busy)
  );

  // Behavioural ALU wrapper: combinational O, flags and accumulator registered on enable.
  logic [7:0]  wf_q;
  logic [15:0] wa_q;
  logic        w_cin, w_h, w_c;
  logic [15:0] w_o;

  always_comb begin
    w_cin = ((alu_op == ALU_ADC) || (alu_op == ALU_SBC)) ? wf_q[FLAG_C] : 1'b0;
    w_o   = alu_x;
    w_h   = 1'b0;
    w_c   = 1'b0;
    case (alu_op)
      ALU_ADD, ALU_ADC: begin
        w_o = alu_x + alu_y + 16'(w_cin);
        w_h = (5'(alu_x[3:0]) + 5'(alu_y[3:0]) + 5'(w_cin)) > 5'd15;
        w_c = (9'(alu_x[7:0]) + 9'(alu_y[7:0]) + 9'(w_cin)) > 9'd255;
      end
      ALU_SUB, ALU_SBC: begin
        w_o = alu_x - alu_y - 16'(w_cin);
        w_h = 5'(alu_x[3:0]) < (5'(alu_y[3:0]) + 5'(w_cin));
        w_c = 9'(alu_x[7:0]) < (9'(alu_y[7:0]) + 9'(w_cin));
      end
      8'h04: w_o = alu_x & alu_y;
      8'h05: w_o = alu_x | alu_y;
      8'h06: w_o = alu_x ^ alu_y;
      default: ;
    endcase
  end

  assign alu_o = w_o;
  assign alu_f = wf_q;

  always @(posedge clk) begin
    if (!reset) begin
      wf_q <= 8'h00;
      wa_q <= 16'h0000;
    end else if (alu_enable) begin
      wf_q <= {4'h0, (w_o == 16'h0), w_o[15], w_h, w_c};
      if (alu_writeA) wa_q <= w_o;
    end
  end

  // Activity counters sampled on the falling edge.
  int en_cnt = 0, wa_cnt = 0, wa_noen = 0, rv_cnt = 0;
  always @(negedge clk) begin
    if (alu_enable) en_cnt <= en_cnt + 1;
    if (alu_writeA) wa_cnt <= wa_cnt + 1;
    if (alu_writeA && !alu_enable) wa_noen <= wa_noen + 1;
    if (bus.res_valid) rv_cnt <= rv_cnt + 1;
  end

  int n_cmp = 0, n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Command-level reference model: carry and accumulator persist across commands.
  logic        model_c = 1'b0;
  logic [15:0] model_a = 16'h0;

  task automatic model_cmd(input logic [7:0] op, input logic [15:0] x, input logic [15:0] y,
                           input logic wide, input logic write,
                           output logic [15:0] d, output logic [3:0] f, output logic [3:0] mask,
                           output logic ew);
    int xi, yi, ci, r;
    logic c, h;
    xi = int'(x);
    yi = int'(y);
    ew = wide && (op == ALU_ADD || op == ALU_SUB);
    c = 1'b0;
    h = 1'b0;
    if (ew) begin
      if (op == ALU_ADD) begin
        r = xi + yi;
        c = (r > 65535);
      end else begin
        r = xi - yi;
        c = (xi < yi);
      end
      d    = 16'(r);
      f    = {(d == 16'h0), 1'b0, 1'b0, c};
      mask = 4'b1001;
    end else begin
      ci = (op == ALU_ADC || op == ALU_SBC) ? int'(model_c) : 0;
      case (op)
        ALU_ADD, ALU_ADC: begin
          r = xi + yi + ci;
          c = ((xi % 256) + (yi % 256) + ci) > 255;
          h = ((xi % 16) + (yi % 16) + ci) > 15;
        end
        ALU_SUB, ALU_SBC: begin
          r = xi - yi - ci;
          c = (xi % 256) < ((yi % 256) + ci);
          h = (xi % 16) < ((yi % 16) + ci);
        end
        8'h04: r = xi & yi;
        8'h05: r = xi | yi;
        8'h06: r = xi ^ yi;
        default: r = xi;
      endcase
      d    = 16'(r);
      f    = {(d == 16'h0), d[15], h, c};
      mask = 4'hF;
      if (write) model_a = d;
    end
    model_c = c;
  endtask

  logic [7:0]  c_op   [NCMD];
  logic [15:0] c_x    [NCMD];
  logic [15:0] c_y    [NCMD];
  logic        c_wide [NCMD];
  logic        c_wr   [NCMD];
  int          c_hold [NCMD];
  logic        c_pre  [NCMD];

  task automatic set_cmd(input int i, input logic [7:0] op, input logic [15:0] x, input logic [15:0] y,
                         input logic wide, input logic wr, input int hold, input logic pre);
    c_op[i] = op; c_x[i] = x; c_y[i] = y; c_wide[i] = wide; c_wr[i] = wr;
    c_hold[i] = hold; c_pre[i] = pre;
  endtask

  task automatic drive_fields(input int i);
    bus.cmd_op    = c_op[i];
    bus.cmd_x     = c_x[i];
    bus.cmd_y     = c_y[i];
    bus.cmd_wide  = c_wide[i];
    bus.cmd_write = c_wr[i];
  endtask

  // Issue command i (called on a falling edge), check the result, then hand it off.
  task automatic run_cmd(input int i);
    int wait_n, lat, en0, wa0;
    logic [15:0] d;
    logic [3:0]  f, mask;
    logic        ew;
    drive_fields(i);
    bus.cmd_valid = 1'b1;
    wait_n = 0;
    while (!bus.cmd_ready && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    check_val("accept_wait", wait_n, 0);
    en0 = en_cnt;
    wa0 = wa_cnt;
    model_cmd(c_op[i], c_x[i], c_y[i], c_wide[i], c_wr[i], d, f, mask, ew);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (!bus.res_valid && lat < 10) begin
      @(negedge clk);
      lat++;
      if (ew && lat == 2) begin
        check_val("hi_op", alu_op, (c_op[i] == ALU_ADD) ? ALU_ADC : ALU_SBC);
        check_val("hi_x", alu_x, {8'h00, c_x[i][15:8]});
      end
    end
    check_val("latency", lat, ew ? 3 : 2);
    check_val("res_data", bus.res_data, d);
    check_val("res_flags", bus.res_flags & mask, f & mask);
    check_val("busy_done", busy, 1);
    check_val("en_pulses", en_cnt - en0, ew ? 2 : 1);
    check_val("wa_pulses", wa_cnt - wa0, (!ew && c_wr[i]) ? 1 : 0);
    if (!ew && c_wr[i]) check_val("acc", wa_q, model_a);
    if (c_pre[i] && i + 1 < NCMD) begin
      drive_fields(i + 1);
      bus.cmd_valid = 1'b1;
    end
    for (int k = 0; k < c_hold[i]; k++) begin
      @(negedge clk);
      check_val("hold_data", bus.res_data, d);
      check_val("hold_flags", bus.res_flags & mask, f & mask);
      check_val("hold_ready", bus.cmd_ready, 0);
      check_val("hold_valid", bus.res_valid, 1);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check_val("idle_ready", bus.cmd_ready, 1);
    check_val("idle_valid", bus.res_valid, 0);
    check_val("idle_busy", busy, 0);
  endtask

  task automatic reset_abort();
    int rv0, wait_n;
    bus.cmd_op = ALU_ADD; bus.cmd_x = 16'h1234; bus.cmd_y = 16'h5678;
    bus.cmd_wide = 1'b1; bus.cmd_write = 1'b0;
    bus.cmd_valid = 1'b1;
    wait_n = 0;
    while (!bus.cmd_ready && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    check_val("abort_accept", wait_n, 0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check_val("abort_hi_beat", {alu_enable, alu_op}, {1'b1, ALU_ADC});
    rv0 = rv_cnt;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_val("post_rst_busy", busy, 0);
    check_val("post_rst_valid", bus.res_valid, 0);
    check_val("post_rst_ready", bus.cmd_ready, 1);
    check_val("post_rst_en", {alu_enable, alu_writeA}, 0);
    repeat (5) @(negedge clk);
    check_val("abort_no_result", rv_cnt - rv0, 0);
    model_c = 1'b0;
    model_a = 16'h0;
  endtask

  initial begin
    reset = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_x = '0; bus.cmd_y = '0;
    bus.cmd_wide = 1'b0; bus.cmd_write = 1'b0; bus.res_ready = 1'b0;

    set_cmd(0, ALU_ADD, 16'h0012, 16'h0034, 1'b0, 1'b1, 0, 1'b0);
    set_cmd(1, ALU_ADD, 16'h12FF, 16'h0001, 1'b1, 1'b1, 0, 1'b0);
    set_cmd(2, ALU_SUB, 16'h0100, 16'h0100, 1'b1, 1'b0, 0, 1'b0);
    set_cmd(3, ALU_SUB, 16'h0001, 16'h0002, 1'b1, 1'b0, 1, 1'b0);
    set_cmd(4, ALU_ADD, 16'h00F0, 16'h0020, 1'b0, 1'b1, 5, 1'b1);
    set_cmd(5, ALU_ADC, 16'h1000, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
    set_cmd(6, ALU_ADD, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 0, 1'b0);
    set_cmd(7, 8'h06,   16'hA5A5, 16'h0F0F, 1'b1, 1'b1, 0, 1'b0);
    for (int i = 8; i < NCMD; i++)
      set_cmd(i, 8'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    repeat (3) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_valid", bus.res_valid, 0);
    check_val("rst_ready", bus.cmd_ready, 1);
    check_val("rst_alu", {alu_enable, alu_writeA, alu_op, alu_x, alu_y}, 0);
    check_val("rst_res", {bus.res_data, bus.res_flags}, 0);
    reset = 1'b1;
    @(negedge clk);

    reset_abort();
    for (int i = 0; i < NCMD; i++) run_cmd(i);
    check_val("wa_without_en", wa_noen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
